// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with burst-boundary tracking for up to 16 masters.
// Optional locked-transfer support is enabled by defining AHB_ARBITER_LOCK_EN.
module ahb_arbiter #(
    parameter int NUM_MASTER = 4,
    parameter int DEF_MASTER = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [NUM_MASTER-1:0] HBUSREQ,
    input  logic [NUM_MASTER-1:0] HLOCK,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
    input  logic                  HREADY,
    output logic [NUM_MASTER-1:0] HGRANT,
    output logic [3:0]            HMASTER,
    output logic                  HMASTLOCK
);

    localparam logic [3:0] DEF_IDX = 4'(DEF_MASTER);
    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;

    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [3:0] owner;
    logic [3:0] owner_next;
    logic [4:0] cand;
    logic       found;
    logic       window;
    logic       owner_locked;

    function automatic logic [3:0] burst_last(input logic [2:0] burst);
        case (burst)
            3'd2, 3'd3: burst_last = 4'd3;
            3'd4, 3'd5: burst_last = 4'd7;
            3'd6, 3'd7: burst_last = 4'd15;
            default:    burst_last = 4'd0;
        endcase
    endfunction

    function automatic logic [NUM_MASTER-1:0] onehot(input logic [3:0] idx);
        onehot = {{(NUM_MASTER-1){1'b0}}, 1'b1} << idx;
    endfunction

`ifdef AHB_ARBITER_LOCK_EN
    assign owner_locked = |(HLOCK & onehot(owner));
`else
    logic unused_lock;
    assign unused_lock  = ^HLOCK;
    assign owner_locked = 1'b0;
`endif

    always_comb begin
        cnt_next = cnt;
        if (HTRANS == TRANS_NONSEQ)
            cnt_next = burst_last(HBURST);
        else if (HTRANS == TRANS_SEQ && cnt != 4'd0)
            cnt_next = cnt - 4'd1;
    end

    assign window = HREADY && (cnt_next == 4'd0);

    // Search owner+1 upward with wrap; the current owner is the last candidate.
    always_comb begin
        owner_next = owner;
        cand       = '0;
        found      = 1'b0;
        if (window && !owner_locked) begin
            owner_next = DEF_IDX;
            for (int i = 1; i <= NUM_MASTER; i++) begin
                cand = 5'(owner) + 5'(i);
                if (cand >= 5'(NUM_MASTER))
                    cand = cand - 5'(NUM_MASTER);
                if (!found && |(HBUSREQ & onehot(cand[3:0]))) begin
                    owner_next = cand[3:0];
                    found      = 1'b1;
                end
            end
        end
    end

    // HMASTER/HMASTLOCK trail the grant by one ready edge (address-phase owner).
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt       <= 4'd0;
            owner     <= DEF_IDX;
            HGRANT    <= onehot(DEF_IDX);
            HMASTER   <= DEF_IDX;
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            cnt       <= cnt_next;
            owner     <= owner_next;
            HGRANT    <= onehot(owner_next);
            HMASTER   <= owner;
            HMASTLOCK <= owner_locked;
        end
    end

endmodule
